fetch_prefetch_queue: RTL and testbench

- Instruction fetch front-end between instruction memory and the IF/ID pipeline register.
- Owns the fetch PC and issues requests to a wait-state instruction memory.
- Buffers fetched words in a small FIFO and presents {instruction, PC+4} to ID with a valid/stall handshake.
- Accepts redirects (branch/jump/jr target from the PC-source mux), which flush all buffered and in-progress fetches.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_prefetch_queue_if.sv | 26 ++
 rtl/fetch_prefetch_queue_instr_fifo.sv | 57 +++++
 rtl/fetch_prefetch_queue.sv | 107 ++++++++++
 tb/tb_fetch_prefetch_queue.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus bundle: redirect/stall from the pipeline, the
// instruction memory handshake and the head-of-queue view toward ID.
interface fetch_prefetch_queue_if;

  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;

  modport master (
    input  Redirect, RedirectPC, Stall, imem_ack, imem_data,
    output imem_req, imem_addr, out_valid, out_instr, out_pc4
  );

  modport slave (
    output Redirect, RedirectPC, Stall, imem_ack, imem_data,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc4
  );

endinterface

// File: rtl/fetch_prefetch_queue_instr_fifo.sv
// Synchronous FIFO of fetched {instr, pc4} entries. Clear wins over
// push/pop; the head is read straight out of the entry registers.
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             push_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, requests words from a
// wait-state instruction memory and queues them for ID.
// Optional build macro FETCH_PERF_EN adds saturating perf counters.
//
// state | meaning
// BOOT  | first cycle out of reset, no request
// RUN   | fetching while the queue has room
// FLUSH | one bubble after a redirect, no request
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                    Clk,
  input  logic                    Rst,
  fetch_prefetch_queue_if.master  bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_flushed,
  output logic [31:0]             perf_stall
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t   state;
  fetch_state_t   state_nxt;
  logic [31:0]    fetch_pc;
  logic           req;
  logic           xfer;
  logic           pop;
  logic           out_valid;
  logic [CW-1:0]  count;
  fetch_entry_t   head;
  fetch_entry_t   push_entry;

  // Next state and request; a redirect always forces the flush bubble.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     req = (count < CW'(DEPTH)) && !bus.Redirect;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
    if (bus.Redirect) state_nxt = FLUSH;
  end

  // State register and fetch PC; redirect target is forced word aligned.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (bus.Redirect)  fetch_pc <= bus.RedirectPC & ~32'h3;
      else if (xfer)     fetch_pc <= fetch_pc + 32'd4;
    end
  end

  assign xfer       = req && bus.imem_ack;
  assign out_valid  = (count != '0);
  assign pop        = out_valid && !bus.Stall && !bus.Redirect;
  assign push_entry = '{instr: bus.imem_data, pc4: fetch_pc + 32'd4};

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? head.instr : NOP_INSTR;
  assign bus.out_pc4   = out_valid ? head.pc4   : 32'h0;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (Clk),
    .rst        (Rst),
    .clear      (bus.Redirect),
    .push       (xfer),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
    .count      (count)
  );

`ifdef FETCH_PERF_EN
  logic [32:0] flush_sum;
  assign flush_sum = {1'b0, perf_flushed} + 33'(count);

  // Saturating counters for transfers, flushed entries and stalled cycles.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      if (xfer && (perf_fetched != '1))
        perf_fetched <= perf_fetched + 32'd1;
      if (out_valid && bus.Stall && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
      if (bus.Redirect)
        perf_flushed <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue against a queue-based model.
module tb_fetch_prefetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  fetch_prefetch_queue_if bus();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.master)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed),
    .perf_stall   (perf_stall)
`endif
  );

  // Reference model: queue of entries, fetch PC, cycles left without request.
  fetch_entry_t mq[$];
  logic [31:0]  m_pc;
  int           m_bubble;
  logic [31:0]  m_fetched, m_flushed, m_stall;
  logic         e_req, e_valid;
  logic [97:0]  e_vec;
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc_no = 0;

  function automatic logic [97:0] obs_vec();
    return {bus.imem_req, bus.imem_req ? bus.imem_addr : 32'h0,
            bus.out_valid, bus.out_instr, bus.out_pc4};
  endfunction

  task automatic set_in(input logic rd, input logic [31:0] rpc, input logic st,
                        input logic ak, input logic [31:0] dt);
    bus.Redirect   = rd;
    bus.RedirectPC = rpc;
    bus.Stall      = st;
    bus.imem_ack   = ak;
    bus.imem_data  = dt;
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc      = RST_PC;
    m_bubble  = 1;
    m_fetched = 0;
    m_flushed = 0;
    m_stall   = 0;
  endtask

  task automatic eval_model();
    logic [31:0] hi, hp;
    @(negedge Clk);
    e_req   = (m_bubble == 0) && (mq.size() < DEPTH) && !bus.Redirect;
    e_valid = (mq.size() != 0);
    hi = NOP_INSTR;
    hp = 32'h0;
    if (mq.size() != 0) begin
      hi = mq[0].instr;
      hp = mq[0].pc4;
    end
    e_vec = {e_req, e_req ? m_pc : 32'h0, e_valid, hi, hp};
  endtask

  task automatic adv();
    fetch_entry_t ent;
    if (e_valid && bus.Stall) m_stall++;
    if (bus.Redirect) begin
      m_flushed += 32'(mq.size());
      mq.delete();
      m_pc     = bus.RedirectPC & ~32'h3;
      m_bubble = 1;
    end else begin
      if (mq.size() != 0 && !bus.Stall) void'(mq.pop_front());
      if (e_req && bus.imem_ack) begin
        ent = {bus.imem_data, m_pc + 32'd4};
        mq.push_back(ent);
        m_pc += 32'd4;
        m_fetched++;
      end
      if (m_bubble > 0) m_bubble--;
    end
    @(posedge Clk);
    #1;
    cyc_no++;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    bit seen;
    seen = 0;
    Rst = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    model_reset();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    n_vec++;
    if ({bus.imem_req, bus.out_valid, bus.out_instr, bus.out_pc4} !== 66'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%b valid=%b instr=%h pc4=%h, expected all zero",
               bus.imem_req, bus.out_valid, bus.out_instr, bus.out_pc4);
    end
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 32'h0, 1'b0, 1'b1, m_pc);
      eval_model();
      if (i == 0) begin
        n_vec++;
        if (bus.imem_req !== 1'b0) begin
          n_err++;
          $display("FAIL boot_req: got %b expected 0", bus.imem_req);
        end
      end
      if (bus.out_valid === 1'b1 && !seen) begin
        seen = 1;
        n_vec++;
        if ({bus.out_instr, bus.out_pc4} !== {32'h0, 32'h4}) begin
          n_err++;
          $display("FAIL first_entry: got instr=%h pc4=%h expected 0/4", bus.out_instr, bus.out_pc4);
        end
      end
      n_vec++;
      if (obs_vec() !== e_vec) begin
        n_err++;
        $display("FAIL boot_seq cyc %0d: got %h expected %h", cyc_no, obs_vec(), e_vec);
      end
      adv();
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL first_valid: got no valid entry, expected one within 8 cycles");
    end
  endtask

  task automatic test_fill_full();
    int xfers;
    bit resumed;
    logic [31:0] pops[$];
    xfers = 0;
    resumed = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 32'h0, 1'b1, 1'b1, m_pc);
      eval_model();
      if (bus.imem_req === 1'b1) xfers++;
      n_vec++;
      if (obs_vec() !== e_vec) begin
        n_err++;
        $display("FAIL fill cyc %0d: got %h expected %h", cyc_no, obs_vec(), e_vec);
      end
      adv();
    end
    n_vec++;
    if (xfers != DEPTH) begin
      n_err++;
      $display("FAIL fill_xfers: got %0d expected %0d", xfers, DEPTH);
    end
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 32'h0, 1'b0, 1'b1, m_pc);
      eval_model();
      if (bus.out_valid === 1'b1) pops.push_back(bus.out_instr);
      if (bus.imem_req === 1'b1) resumed = 1;
      n_vec++;
      if (obs_vec() !== e_vec) begin
        n_err++;
        $display("FAIL drain cyc %0d: got %h expected %h", cyc_no, obs_vec(), e_vec);
      end
      adv();
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (pops.size() <= k || pops[k] !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL drain_order[%0d]: got %h expected %h", k,
                 (pops.size() > k) ? pops[k] : 32'hDEAD_BEEF, 32'(4 * k));
      end
    end
    n_vec++;
    if (!resumed) begin
      n_err++;
      $display("FAIL req_resume: got no request after release, expected one");
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] seen[$];
    do_reset();
    for (int i = 0; i < 14; i++) begin
      set_in(1'b0, 32'h0, 1'b0, (i % 3) == 2, m_pc);
      eval_model();
      if (bus.out_valid === 1'b1) seen.push_back(bus.out_pc4);
      n_vec++;
      if (obs_vec() !== e_vec) begin
        n_err++;
        $display("FAIL wait_state cyc %0d: got %h expected %h", cyc_no, obs_vec(), e_vec);
      end
      adv();
    end
    n_vec++;
    if (seen.size() != 4) begin
      n_err++;
      $display("FAIL wait_count: got %0d entries expected 4", seen.size());
    end
    for (int k = 0; k < 4 && k < seen.size(); k++) begin
      n_vec++;
      if (seen[k] !== 32'(4 * (k + 1))) begin
        n_err++;
        $display("FAIL wait_pc4[%0d]: got %h expected %h", k, seen[k], 32'(4 * (k + 1)));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      case (i)
        4:       set_in(1'b1, 32'h0000_0103, 1'b1, 1'b1, m_pc);
        5:       set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        6:       set_in(1'b0, 32'h0, 1'b0, 1'b1, m_pc);
        7:       set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        default: set_in(1'b0, 32'h0, 1'b1, 1'b1, m_pc);
      endcase
      eval_model();
      if (i == 5) begin
        n_vec++;
        if ({bus.imem_req, bus.out_valid, bus.out_instr} !== 34'h0) begin
          n_err++;
          $display("FAIL flush_bubble: got req=%b valid=%b instr=%h expected 0/0/0",
                   bus.imem_req, bus.out_valid, bus.out_instr);
        end
      end
      if (i == 6) begin
        n_vec++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0000_0100}) begin
          n_err++;
          $display("FAIL redirect_addr: got req=%b addr=%h expected 1/00000100", bus.imem_req, bus.imem_addr);
        end
      end
      if (i == 7) begin
        n_vec++;
        if ({bus.out_valid, bus.out_instr, bus.out_pc4} !== {1'b1, 32'h0000_0100, 32'h0000_0104}) begin
          n_err++;
          $display("FAIL redirect_head: got valid=%b instr=%h pc4=%h expected 1/00000100/00000104",
                   bus.out_valid, bus.out_instr, bus.out_pc4);
        end
      end
      n_vec++;
      if (obs_vec() !== e_vec) begin
        n_err++;
        $display("FAIL redirect cyc %0d: got %h expected %h", cyc_no, obs_vec(), e_vec);
      end
      adv();
    end
  endtask

  task automatic test_back_to_back();
    bit bad;
    logic [31:0] first_pc4;
    bad = 0;
    first_pc4 = 32'hFFFF_FFFF;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i == 3)      set_in(1'b1, 32'h0000_0200, 1'b1, 1'b1, m_pc);
      else if (i == 4) set_in(1'b1, 32'h0000_0300, 1'b1, 1'b1, m_pc);
      else             set_in(1'b0, 32'h0, i > 4 ? 1'b0 : 1'b1, 1'b1, m_pc);
      eval_model();
      if (i > 4) begin
        if (bus.imem_req === 1'b1 && bus.imem_addr[31:8] == 24'h2) bad = 1;
        if (bus.out_valid === 1'b1 && bus.out_pc4[31:8] == 24'h2) bad = 1;
        if (bus.out_valid === 1'b1 && first_pc4 == 32'hFFFF_FFFF) first_pc4 = bus.out_pc4;
      end
      n_vec++;
      if (obs_vec() !== e_vec) begin
        n_err++;
        $display("FAIL b2b cyc %0d: got %h expected %h", cyc_no, obs_vec(), e_vec);
      end
      adv();
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL b2b_stale: got activity from 0x200 region, expected none");
    end
    n_vec++;
    if (first_pc4 !== 32'h0000_0304) begin
      n_err++;
      $display("FAIL b2b_first: got pc4=%h expected 00000304", first_pc4);
    end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] addrs[$];
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i == 1) set_in(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, m_pc);
      else        set_in(1'b0, 32'h0, 1'b1, 1'b1, m_pc);
      eval_model();
      if (i > 1 && bus.imem_req === 1'b1) addrs.push_back(bus.imem_addr);
      if (i == 6) begin
        n_vec++;
        if ({bus.out_instr, bus.out_pc4} !== {32'hFFFF_FFFC, 32'h0}) begin
          n_err++;
          $display("FAIL wrap_head: got instr=%h pc4=%h expected FFFFFFFC/00000000",
                   bus.out_instr, bus.out_pc4);
        end
      end
      n_vec++;
      if (obs_vec() !== e_vec) begin
        n_err++;
        $display("FAIL wrap cyc %0d: got %h expected %h", cyc_no, obs_vec(), e_vec);
      end
      adv();
    end
    n_vec++;
    if (addrs.size() < 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_addrs: got %0d addrs first=%h second=%h expected FFFFFFFC then 00000000",
               addrs.size(), (addrs.size() > 0) ? addrs[0] : 32'hDEAD_BEEF,
               (addrs.size() > 1) ? addrs[1] : 32'hDEAD_BEEF);
    end
    set_in(1'b0, 32'h0, 1'b1, 1'b1, m_pc);
    #2;
    n_vec++;
    if (bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL prereset_valid: got %b expected 1", bus.out_valid);
    end
    Rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.imem_req, bus.out_valid, bus.out_instr, bus.out_pc4} !== 66'h0) begin
      n_err++;
      $display("FAIL async_reset: got req=%b valid=%b instr=%h pc4=%h expected all zero",
               bus.imem_req, bus.out_valid, bus.out_instr, bus.out_pc4);
    end
    model_reset();
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 32'h0, 1'b0, 1'b1, m_pc);
      eval_model();
      n_vec++;
      if (obs_vec() !== e_vec) begin
        n_err++;
        $display("FAIL post_reset cyc %0d: got %h expected %h", cyc_no, obs_vec(), e_vec);
      end
      adv();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(15) == 0, $urandom, $urandom_range(2) == 0,
             $urandom_range(1) == 1, $urandom);
      eval_model();
      n_vec++;
      if (obs_vec() !== e_vec) begin
        n_err++;
        $display("FAIL random cyc %0d: got %h expected %h", cyc_no, obs_vec(), e_vec);
      end
      adv();
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_PERF_EN
    @(negedge Clk);
    n_vec++;
    if ({perf_fetched, perf_flushed, perf_stall} !== {m_fetched, m_flushed, m_stall}) begin
      n_err++;
      $display("FAIL perf: got %0d/%0d/%0d expected %0d/%0d/%0d", perf_fetched, perf_flushed,
               perf_stall, m_fetched, m_flushed, m_stall);
    end
`endif
  endtask

  initial begin
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_fill_full();
    test_wait_states();
    test_redirect();
    test_back_to_back();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
